// File: rtl/usr_shift_ctrl_if.sv
// Command/response handshake bundle between a host sequencer and usr_shift_ctrl.
// The host drives the master side; the controller is the slave.
interface usr_shift_ctrl_if #(
    parameter int MAX_CNT = 8
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [2:0]         cmd_op;
    logic [3:0]         cmd_count;
    logic [3:0]         cmd_data;
    logic               cmd_fill;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [3:0]         rsp_data;
    logic [MAX_CNT-1:0] rsp_sout;
    logic               rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_count, cmd_data, cmd_fill, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_sout, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_count, cmd_data, cmd_fill, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_sout, rsp_err
    );
endinterface

// File: rtl/usr_shift_ctrl.sv
// Sequencer for a 4-bit universal shift register: runs load/shift/rotate commands
// and returns the final word plus every bit shifted out.
module usr_shift_ctrl #(
    parameter int MAX_CNT = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    usr_shift_ctrl_if.slave        bus,
    output logic [1:0]             usr_select,
    output logic [3:0]             usr_p_din,
    output logic                   usr_s_left_din,
    output logic                   usr_s_right_din,
    input  logic [3:0]             usr_p_dout,
    input  logic                   usr_s_left_dout,
    input  logic                   usr_s_right_dout
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [3:0] MAX_CNT4 = 4'(MAX_CNT);

    state_t             state_r, state_s;
    logic [2:0]         op_r;
    logic [3:0]         cnt_r;
    logic [3:0]         step_r;
    logic [3:0]         data_r;
    logic               fill_r;
    logic [MAX_CNT-1:0] sout_r;
    logic               err_r;

    logic               accept_s;
    logic               illegal_s;
    logic [3:0]         count_sat_s;
    logic               right_op_s;
    logic               shift_out_s;

    assign bus.cmd_ready = (state_r == ST_IDLE) && reset;
    assign accept_s      = bus.cmd_valid && bus.cmd_ready;
    assign illegal_s     = (bus.cmd_op > OP_ROL);
    assign count_sat_s   = (bus.cmd_count > MAX_CNT4) ? MAX_CNT4 : bus.cmd_count;
    assign right_op_s    = (op_r == OP_SHR) || (op_r == OP_ROR);
    assign shift_out_s   = right_op_s ? usr_s_right_dout : usr_s_left_dout;

    // The register holds in RESP, so its output is the response word.
    assign bus.rsp_valid = (state_r == ST_RESP);
    assign bus.rsp_data  = usr_p_dout;
    assign bus.rsp_sout  = sout_r;
    assign bus.rsp_err   = err_r;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (bus.cmd_op == OP_LOAD) begin
                        state_s = ST_LOAD;
                    end else if (illegal_s || (count_sat_s == 4'd0)) begin
                        state_s = ST_RESP;
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD:  state_s = ST_RESP;
            ST_SHIFT: begin
                if (cnt_r <= 4'd1) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Command latch, step counter and serial-out capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_r   <= 3'b000;
            cnt_r  <= 4'd0;
            step_r <= 4'd0;
            data_r <= 4'b0000;
            fill_r <= 1'b0;
            sout_r <= '0;
            err_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r   <= bus.cmd_op;
                        cnt_r  <= count_sat_s;
                        step_r <= 4'd0;
                        data_r <= bus.cmd_data;
                        fill_r <= bus.cmd_fill;
                        sout_r <= '0;
                        err_r  <= illegal_s;
                    end
                end
                ST_SHIFT: begin
                    for (int i = 0; i < MAX_CNT; i++) begin
                        if (step_r == 4'(i)) begin
                            sout_r[i] <= shift_out_s;
                        end
                    end
                    cnt_r  <= cnt_r - 4'd1;
                    step_r <= step_r + 4'd1;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Register control decode from state/op flops only; rotates feed the outgoing bit back.
    always_comb begin
        usr_select      = 2'b00;
        usr_p_din       = 4'b0000;
        usr_s_left_din  = 1'b0;
        usr_s_right_din = 1'b0;
        case (state_r)
            ST_LOAD: begin
                usr_select = 2'b11;
                usr_p_din  = data_r;
            end
            ST_SHIFT: begin
                if (right_op_s) begin
                    usr_select      = 2'b01;
                    usr_s_right_din = (op_r == OP_SHR) ? fill_r : usr_s_right_dout;
                end else begin
                    usr_select      = 2'b10;
                    usr_s_left_din  = (op_r == OP_SHL) ? fill_r : usr_s_left_dout;
                end
            end
            default: begin
                usr_select = 2'b00;
            end
        endcase
    end
endmodule

// File: tb/tb_usr_shift_ctrl.sv
// Directed bench for usr_shift_ctrl driving a behavioural 4-bit universal shift register.
module tb_usr_shift_ctrl;
    logic       clk;
    logic       reset;
    logic [1:0] usr_select;
    logic [3:0] usr_p_din;
    logic       usr_s_left_din;
    logic       usr_s_right_din;
    logic [3:0] reg_q;

    int total;
    int bad;
    int lat_v;
    int selcnt_v;
    logic [1:0] lastsel_v;

    usr_shift_ctrl_if #(.MAX_CNT(8)) bus_if ();

    usr_shift_ctrl #(.MAX_CNT(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus_if),
        .usr_select       (usr_select),
        .usr_p_din        (usr_p_din),
        .usr_s_left_din   (usr_s_left_din),
        .usr_s_right_din  (usr_s_right_din),
        .usr_p_dout       (reg_q),
        .usr_s_left_dout  (reg_q[3]),
        .usr_s_right_dout (reg_q[0])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Universal shift register model: 01 right (serial in at bit 3), 10 left (in at bit 0), 11 load.
    always_ff @(posedge clk) begin
        case (usr_select)
            2'b01:   reg_q <= {usr_s_right_din, reg_q[3:1]};
            2'b10:   reg_q <= {reg_q[2:0], usr_s_left_din};
            2'b11:   reg_q <= usr_p_din;
            default: reg_q <= reg_q;
        endcase
    end

    task automatic do_cmd(input logic [2:0] op, input logic [3:0] cnt,
                          input logic [3:0] data, input logic fill);
        int w;
        @(negedge clk);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_op    = op;
        bus_if.cmd_count = cnt;
        bus_if.cmd_data  = data;
        bus_if.cmd_fill  = fill;
        w = 0;
        while (!bus_if.cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        total++;
        if (w >= 20) begin
            bad++;
            $display("FAIL cmd_accept: cmd_ready=%b required 1", bus_if.cmd_ready);
        end
        @(posedge clk);
        #1;
        bus_if.cmd_valid = 1'b0;
        lat_v     = 0;
        selcnt_v  = 0;
        lastsel_v = 2'b00;
        while (!bus_if.rsp_valid && lat_v < 40) begin
            if (usr_select != 2'b00) begin
                selcnt_v++;
                lastsel_v = usr_select;
            end
            @(posedge clk);
            #1;
            lat_v++;
        end
    endtask

    task automatic finish_rsp();
        bus_if.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        total++; if (bus_if.cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_cmd_ready: got %b want 0", bus_if.cmd_ready); end
        total++; if (usr_select !== 2'b00) begin bad++; $display("FAIL rst_select: got %b want 00", usr_select); end
        total++; if (usr_p_din !== 4'b0000) begin bad++; $display("FAIL rst_p_din: got %b want 0000", usr_p_din); end
        total++; if (bus_if.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid: got %b want 0", bus_if.rsp_valid); end
        total++; if (bus_if.rsp_sout !== 8'h00 || bus_if.rsp_err !== 1'b0) begin
            bad++; $display("FAIL rst_rsp: sout=%h err=%b want 00/0", bus_if.rsp_sout, bus_if.rsp_err); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (bus_if.cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", bus_if.cmd_ready); end
    endtask

    task automatic test_load();
        do_cmd(3'b000, 4'd0, 4'b1011, 1'b0);
        total++; if (lat_v != 1) begin bad++; $display("FAIL load_lat: got %0d want 1", lat_v); end
        total++; if (selcnt_v != 1 || lastsel_v !== 2'b11) begin
            bad++; $display("FAIL load_sel: cycles=%0d sel=%b want 1/11", selcnt_v, lastsel_v); end
        total++; if (bus_if.rsp_data !== 4'b1011) begin bad++; $display("FAIL load_data: got %b want 1011", bus_if.rsp_data); end
        total++; if (bus_if.rsp_sout !== 8'h00 || bus_if.rsp_err !== 1'b0) begin
            bad++; $display("FAIL load_rsp: sout=%h err=%b want 00/0", bus_if.rsp_sout, bus_if.rsp_err); end
        finish_rsp();
    endtask

    task automatic test_shr();
        do_cmd(3'b000, 4'd0, 4'b1011, 1'b0);
        finish_rsp();
        do_cmd(3'b001, 4'd2, 4'b0000, 1'b0);
        total++; if (lat_v != 2 || selcnt_v != 2 || lastsel_v !== 2'b01) begin
            bad++; $display("FAIL shr_timing: lat=%0d cycles=%0d sel=%b want 2/2/01", lat_v, selcnt_v, lastsel_v); end
        total++; if (bus_if.rsp_data !== 4'b0010) begin bad++; $display("FAIL shr_data: got %b want 0010", bus_if.rsp_data); end
        total++; if (bus_if.rsp_sout !== 8'h03) begin bad++; $display("FAIL shr_sout: got %h want 03", bus_if.rsp_sout); end
        finish_rsp();
    endtask

    task automatic test_shl();
        do_cmd(3'b000, 4'd0, 4'b1011, 1'b0);
        finish_rsp();
        do_cmd(3'b010, 4'd3, 4'b0000, 1'b1);
        total++; if (lat_v != 3 || lastsel_v !== 2'b10) begin
            bad++; $display("FAIL shl_timing: lat=%0d sel=%b want 3/10", lat_v, lastsel_v); end
        total++; if (bus_if.rsp_data !== 4'b1111) begin bad++; $display("FAIL shl_data: got %b want 1111", bus_if.rsp_data); end
        total++; if (bus_if.rsp_sout !== 8'h05) begin bad++; $display("FAIL shl_sout: got %h want 05", bus_if.rsp_sout); end
        finish_rsp();
    endtask

    task automatic test_rotate();
        do_cmd(3'b000, 4'd0, 4'b1001, 1'b0);
        finish_rsp();
        do_cmd(3'b011, 4'd5, 4'b0000, 1'b0);
        total++; if (lat_v != 5) begin bad++; $display("FAIL ror_lat: got %0d want 5", lat_v); end
        total++; if (bus_if.rsp_data !== 4'b1100) begin bad++; $display("FAIL ror_data: got %b want 1100", bus_if.rsp_data); end
        total++; if (bus_if.rsp_sout !== 8'h19) begin bad++; $display("FAIL ror_sout: got %h want 19", bus_if.rsp_sout); end
        finish_rsp();
        do_cmd(3'b100, 4'd12, 4'b0000, 1'b0);
        total++; if (lat_v != 8 || selcnt_v != 8 || lastsel_v !== 2'b10) begin
            bad++; $display("FAIL rol_sat: lat=%0d cycles=%0d sel=%b want 8/8/10", lat_v, selcnt_v, lastsel_v); end
        total++; if (bus_if.rsp_data !== 4'b1100) begin bad++; $display("FAIL rol_data: got %b want 1100", bus_if.rsp_data); end
        total++; if (bus_if.rsp_sout !== 8'h33) begin bad++; $display("FAIL rol_sout: got %h want 33", bus_if.rsp_sout); end
        finish_rsp();
    endtask

    task automatic test_illegal();
        do_cmd(3'b111, 4'd3, 4'b0101, 1'b1);
        total++; if (lat_v != 0 || selcnt_v != 0) begin
            bad++; $display("FAIL ill_lat: lat=%0d cycles=%0d want 0/0", lat_v, selcnt_v); end
        total++; if (bus_if.rsp_err !== 1'b1) begin bad++; $display("FAIL ill_err: got %b want 1", bus_if.rsp_err); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_err !== 1'b1 || bus_if.rsp_data !== 4'b1100 ||
                bus_if.rsp_sout !== 8'h00 || bus_if.cmd_ready !== 1'b0 || usr_select !== 2'b00) begin
                bad++;
                $display("FAIL ill_hold[%0d]: v=%b e=%b d=%b s=%h rdy=%b sel=%b want 1/1/1100/00/0/00",
                         i, bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_data, bus_if.rsp_sout,
                         bus_if.cmd_ready, usr_select);
            end
            @(posedge clk);
            #1;
        end
        finish_rsp();
    endtask

    task automatic test_reset_abort();
        do_cmd(3'b000, 4'd0, 4'b1111, 1'b0);
        finish_rsp();
        @(negedge clk);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_op    = 3'b001;
        bus_if.cmd_count = 4'd4;
        bus_if.cmd_fill  = 1'b0;
        @(posedge clk);
        #1;
        bus_if.cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        total++; if (usr_select !== 2'b00 || bus_if.rsp_valid !== 1'b0) begin
            bad++; $display("FAIL abort_outputs: sel=%b v=%b want 00/0", usr_select, bus_if.rsp_valid); end
        total++; if (bus_if.cmd_ready !== 1'b0) begin bad++; $display("FAIL abort_ready: got %b want 0", bus_if.cmd_ready); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (bus_if.cmd_ready !== 1'b1) begin bad++; $display("FAIL abort_release: got %b want 1", bus_if.cmd_ready); end
        do_cmd(3'b000, 4'd0, 4'b0110, 1'b0);
        total++; if (bus_if.rsp_data !== 4'b0110 || bus_if.rsp_err !== 1'b0 || lat_v != 1) begin
            bad++; $display("FAIL abort_reload: d=%b e=%b lat=%0d want 0110/0/1", bus_if.rsp_data, bus_if.rsp_err, lat_v); end
        finish_rsp();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_op    = 3'b000;
        bus_if.cmd_count = 4'd0;
        bus_if.cmd_data  = 4'b0000;
        bus_if.cmd_fill  = 1'b0;
        bus_if.rsp_ready = 1'b0;
        test_reset();
        test_load();
        test_shr();
        test_shl();
        test_rotate();
        test_illegal();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/usr_shift_ctrl.md
# usr_shift_ctrl

Command sequencer for the 4-bit universal shift register. It accepts load, shift and rotate commands over a valid/ready handshake and drives the register's select and data inputs for the required number of cycles. It captures every bit shifted out and returns the final parallel value and the collected serial bits over a response handshake. It sits between a host/test sequencer and the shift-register datapath, so that nothing else drives the register's controls directly.

## Interface
- `MAX_CNT`, default 8: maximum shift/rotate count. Larger requests saturate to this value. It also sets the width of `rsp_sout`.
- `clk` in 1: single clock; all flops rise-edge.
- `reset` in 1: asynchronous, active-low. Reset is applied immediately; deassertion is synchronous to `clk`.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted on an edge where `cmd_valid & cmd_ready`.
- `cmd_op` in 3: operation. 000 LOAD, 001 SHR, 010 SHL, 011 ROR, 100 ROL; 101–111 are illegal.
- `cmd_count` in 4: number of shift/rotate steps, 0..15. Values above `MAX_CNT` saturate.
- `cmd_data` in 4: parallel word for LOAD.
- `cmd_fill` in 1: serial fill bit for SHR/SHL.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed on an edge where `rsp_valid & rsp_ready`.
- `rsp_data` out 4: register contents after the operation.
- `rsp_sout` out 8: collected outgoing bits. Bit k is the bit shifted out at step k; unused bits are 0.
- `rsp_err` out 1: set when the command used an illegal op.
- `usr_select` out 2: register select. 00 HOLD, 01 SHIFT-RIGHT, 10 SHIFT-LEFT, 11 LOAD.
- `usr_p_din` out 4: register parallel input.
- `usr_s_left_din` out 1: serial input for a left shift (enters at bit 0).
- `usr_s_right_din` out 1: serial input for a right shift (enters at bit 3).
- `usr_p_dout` in 4: register parallel output.
- `usr_s_left_dout` in 1: register bit 3.
- `usr_s_right_dout` in 1: register bit 0.

## Operation
- FSM states: IDLE, LOAD, SHIFT, RESP.
- **IDLE**
  - `cmd_ready = 1`, gated low while `reset` is low.
  - On accept, the controller latches the op, the saturated count, `cmd_data` and `cmd_fill`, and clears `rsp_sout` and `rsp_err`. Next state:
    - LOAD op → LOAD.
    - SHR/SHL/ROR/ROL with count ≥ 1 → SHIFT.
    - Count 0 or illegal op → RESP. For an illegal op, `rsp_err` is set to 1.
- **LOAD**
  - Drives `usr_select = 11` and `usr_p_din` = latched data for exactly one cycle, then goes to RESP.
- **SHIFT**
  - Drives the shift select for each remaining step: 01 for SHR/ROR, 10 for SHL/ROL.
  - Serial input on each step:
    - SHR: `usr_s_right_din` = fill.
    - SHL: `usr_s_left_din` = fill.
    - ROR: `usr_s_right_din = usr_s_right_dout` (combinational feedback).
    - ROL: `usr_s_left_din = usr_s_left_dout` (combinational feedback).
  - On each edge, the outgoing bit is captured into `rsp_sout[step]` and the counter decrements. The outgoing bit is `usr_s_right_dout` for right ops and `usr_s_left_dout` for left ops.
  - When the counter reaches 0, the FSM goes to RESP.
- **RESP**
  - `usr_select = 00` (HOLD).
  - `rsp_valid = 1`, and `rsp_data = usr_p_dout` (stable because the register holds).
  - Goes to IDLE on `rsp_ready`.
  - `rsp_*` stay stable while `rsp_ready` is low.
- **Output decoding**
  - `usr_select` and `usr_p_din` decode from state/op flops only; there is no combinational path from `cmd_*`.
  - Serial-input outputs not named above, and `usr_p_din` outside LOAD, are driven 0.
- **Reset and illegal ops**
  - Reset mid-operation aborts immediately: state returns to IDLE, the command is lost and no response is given.
  - An illegal op never changes the register.

## Timing
- Reset values:
  - state IDLE.
  - `usr_select` 00, `usr_p_din` 0000, `usr_s_left_din` 0, `usr_s_right_din` 0.
  - `cmd_ready` 0 while reset is low, 1 in the first cycle after release.
  - `rsp_valid` 0, `rsp_sout` 0, `rsp_err` 0.
- Latency from the accept edge to the first cycle with `rsp_valid` high:
  - LOAD: 1 edge.
  - Shift/rotate by N: N edges.
  - Count 0 or illegal op: 0 edges (`rsp_valid` is high in the cycle right after accept).
- Throughput: a new command can be accepted no earlier than one cycle after the response handshake, because `cmd_ready` is asserted only in IDLE.
- The register sees the select one cycle after accept and updates on each following edge.

## Test plan
- LOAD `cmd_data=1011` → one cycle with `usr_select=11`; then `rsp_data=1011`, `rsp_sout=0x00`, `rsp_err=0`, latency 1.
- After LOAD 1011, SHR count 2, fill 0 → two cycles with select 01; `rsp_data=0010`, `rsp_sout=0x03`.
- After LOAD 1011, SHL count 3, fill 1 → `rsp_data=1111`, `rsp_sout=0x05`, latency 3.
- After LOAD 1001, ROR count 5 → `rsp_data=1100`, `rsp_sout=0x19`. Also: ROL count 12 saturates to 8 (8 select cycles) and returns the value unchanged.
- Op 111 → `rsp_err=1`, latency 0, `usr_select` stays 00. Holding `rsp_ready` low for 5 cycles → `rsp_*` stable and `cmd_ready=0`.
- Drive `reset` low two edges into SHR count 4 → `usr_select=00` and `rsp_valid=0` immediately. After release, `cmd_ready=1` and a fresh LOAD 0110 returns 0110.
